// File: rtl/mipi_rx_ctrl_pkg.sv
// Shared types and constants for the MIPI CSI-2 RX frame controller.
package mipi_rx_ctrl_pkg;

  localparam int unsigned CNT_W = 16;

  localparam int unsigned ERR_LINE_LEN = 0;
  localparam int unsigned ERR_LINE_CNT = 1;
  localparam int unsigned ERR_TRUNC    = 2;
  localparam int unsigned ERR_TIMEOUT  = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_FS  = 2'd1,
    IN_FRAME = 2'd2,
    RECOVER  = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) sat_inc = v;
    else                    sat_inc = v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/mipi_rx_watchdog.sv
// Clear/load/count counter with a terminal-count pulse; the count wraps to zero on terminal count.
module mipi_rx_watchdog #(
  parameter int unsigned g_WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clr,
  input  logic               i_load,
  input  logic [g_WIDTH-1:0] i_load_val,
  input  logic               i_cnt_en,
  input  logic [g_WIDTH-1:0] i_term,
  output logic               o_tc
);

  logic [g_WIDTH-1:0] r_cnt;
  logic [g_WIDTH-1:0] w_cnt_nxt;

  assign o_tc = i_cnt_en && (r_cnt == i_term);

  // Next count: clear beats load beats terminal wrap beats increment.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clr) begin
      w_cnt_nxt = {g_WIDTH{1'b0}};
    end else if (i_load) begin
      w_cnt_nxt = i_load_val;
    end else if (o_tc) begin
      w_cnt_nxt = {g_WIDTH{1'b0}};
    end else if (i_cnt_en) begin
      w_cnt_nxt = r_cnt + g_WIDTH'(1);
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // Count register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_cnt <= {g_WIDTH{1'b0}};
    else       r_cnt <= w_cnt_nxt;
  end

endmodule

// File: rtl/mipi_rx_frame_ctrl.sv
// Frame-level controller behind the CSI-2 RX decoder: gates the stream, checks frame geometry, recovers stalls.
// Optional macro MIPI_RX_FRAME_CTRL_STATS_EN adds last_lines_o / last_max_beats_o per-frame statistics.
module mipi_rx_frame_ctrl
  import mipi_rx_ctrl_pkg::*;
#(
  parameter int unsigned g_DATAWIDTH     = 10,
  parameter int unsigned g_NUM_OF_PIXELS = 1,
  parameter int unsigned g_H_RES         = 1920,
  parameter int unsigned g_V_RES         = 1080,
  parameter int unsigned g_TIMEOUT       = 1048576,
  parameter int unsigned g_RST_CYCLES    = 16
) (
  input  logic                                   PARALLEL_CLOCK_I,
  input  logic                                   RESET_I,
  input  logic                                   enable_i,
  input  logic                                   clr_err_i,
  input  logic                                   frame_start_i,
  input  logic                                   frame_end_i,
  input  logic                                   line_start_i,
  input  logic                                   line_end_i,
  input  logic                                   line_valid_i,
  input  logic [g_NUM_OF_PIXELS*g_DATAWIDTH-1:0] data_i,
  output logic                                   frame_valid_o,
  output logic                                   line_valid_o,
  output logic [g_NUM_OF_PIXELS*g_DATAWIDTH-1:0] data_o,
  output logic                                   frame_done_o,
  output logic                                   frame_ok_o,
  output logic [3:0]                             err_o,
  output logic [15:0]                            frame_cnt_o,
`ifdef MIPI_RX_FRAME_CTRL_STATS_EN
  output logic [15:0]                            last_lines_o,
  output logic [15:0]                            last_max_beats_o,
`endif
  output logic                                   decoder_rst_o,
  output logic                                   busy_o
);

  localparam int unsigned      c_DW      = g_NUM_OF_PIXELS * g_DATAWIDTH;
  localparam logic [CNT_W-1:0] c_BEATS   = CNT_W'(g_H_RES / g_NUM_OF_PIXELS);
  localparam logic [CNT_W-1:0] c_LINES   = CNT_W'(g_V_RES);
  localparam logic [CNT_W-1:0] c_ZERO    = {CNT_W{1'b0}};
  localparam int unsigned      c_WD_W    = $clog2(g_TIMEOUT + 1);
  localparam int unsigned      c_RC_W    = $clog2(g_RST_CYCLES + 1);
  localparam logic [c_WD_W-1:0] c_WD_TERM = c_WD_W'(g_TIMEOUT - 1);
  localparam logic [c_RC_W-1:0] c_RC_TERM = c_RC_W'(g_RST_CYCLES - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_beats, w_beats_nxt, r_lines, w_lines_nxt, r_max, w_max_nxt;
  logic [CNT_W-1:0] w_beats_eff, w_lines_eff, w_max_eff;
  logic             r_bad, w_bad_nxt;
  logic [3:0]       w_err_set;
  logic             w_done, w_ok, w_line_err, w_cnt_err;
  logic             w_activity, w_timeout, w_rst_done, w_wd_en, w_rc_en, w_gate;

  logic             r_fv, r_lv, r_done, r_ok, r_dec_rst, r_busy;
  logic [c_DW-1:0]  r_data;
  logic [3:0]       r_err;
  logic [15:0]      r_fcnt;

  // A beat or line_end arriving together with frame_end is folded in before the frame is judged.
  assign w_activity  = frame_start_i | frame_end_i | line_start_i | line_end_i | line_valid_i;
  assign w_beats_eff = line_valid_i ? sat_inc(r_beats) : r_beats;
  assign w_lines_eff = line_end_i ? sat_inc(r_lines) : r_lines;
  assign w_max_eff   = (line_end_i && (w_beats_eff > r_max)) ? w_beats_eff : r_max;
  assign w_line_err  = line_end_i && (w_beats_eff != c_BEATS);
  assign w_cnt_err   = w_lines_eff != c_LINES;
  assign w_wd_en     = (r_state == IN_FRAME) && !w_activity;
  assign w_rc_en     = r_state == RECOVER;
  assign w_gate      = ((r_state == IN_FRAME) && !w_timeout) || (w_state_nxt == IN_FRAME);

  mipi_rx_watchdog #(.g_WIDTH(c_WD_W)) u_timeout (
    .i_clk      (PARALLEL_CLOCK_I),
    .i_rst      (RESET_I),
    .i_clr      (!w_wd_en),
    .i_load     (1'b0),
    .i_load_val ({c_WD_W{1'b0}}),
    .i_cnt_en   (w_wd_en),
    .i_term     (c_WD_TERM),
    .o_tc       (w_timeout)
  );

  mipi_rx_watchdog #(.g_WIDTH(c_RC_W)) u_recover (
    .i_clk      (PARALLEL_CLOCK_I),
    .i_rst      (RESET_I),
    .i_clr      (!w_rc_en),
    .i_load     (1'b0),
    .i_load_val ({c_RC_W{1'b0}}),
    .i_cnt_en   (w_rc_en),
    .i_term     (c_RC_TERM),
    .o_tc       (w_rst_done)
  );

  // Next-state, geometry counters and frame verdict.
  always_comb begin
    w_state_nxt = r_state;
    w_beats_nxt = r_beats;
    w_lines_nxt = r_lines;
    w_max_nxt   = r_max;
    w_bad_nxt   = r_bad;
    w_err_set   = 4'b0000;
    w_done      = 1'b0;
    w_ok        = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable_i) w_state_nxt = WAIT_FS;
        else          w_state_nxt = IDLE;
      end
      WAIT_FS: begin
        if (!enable_i) begin
          w_state_nxt = IDLE;
        end else if (frame_start_i) begin
          w_state_nxt = IN_FRAME;
          w_beats_nxt = c_ZERO;
          w_lines_nxt = c_ZERO;
          w_max_nxt   = c_ZERO;
          w_bad_nxt   = 1'b0;
        end else begin
          w_state_nxt = WAIT_FS;
        end
      end
      IN_FRAME: begin
        if (frame_start_i) begin
          w_err_set[ERR_TRUNC] = 1'b1;
          w_done      = 1'b1;
          w_beats_nxt = c_ZERO;
          w_lines_nxt = c_ZERO;
          w_max_nxt   = c_ZERO;
          w_bad_nxt   = 1'b0;
          w_state_nxt = enable_i ? IN_FRAME : IDLE;
        end else if (w_timeout) begin
          w_err_set[ERR_TIMEOUT] = 1'b1;
          w_state_nxt = RECOVER;
        end else begin
          w_beats_nxt = line_end_i ? c_ZERO : w_beats_eff;
          w_lines_nxt = w_lines_eff;
          w_max_nxt   = w_max_eff;
          w_bad_nxt   = r_bad | w_line_err;
          w_err_set[ERR_LINE_LEN] = w_line_err;
          w_err_set[ERR_LINE_CNT] = frame_end_i & w_cnt_err;
          if (frame_end_i) begin
            w_done      = 1'b1;
            w_ok        = ~(r_bad | w_line_err | w_cnt_err);
            w_state_nxt = enable_i ? WAIT_FS : IDLE;
          end else begin
            w_state_nxt = IN_FRAME;
          end
        end
      end
      RECOVER: begin
        if (w_rst_done) w_state_nxt = enable_i ? WAIT_FS : IDLE;
        else            w_state_nxt = RECOVER;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge PARALLEL_CLOCK_I or posedge RESET_I) begin
    if (RESET_I) begin
      r_state   <= IDLE;
      r_beats   <= c_ZERO;
      r_lines   <= c_ZERO;
      r_max     <= c_ZERO;
      r_bad     <= 1'b0;
      r_fv      <= 1'b0;
      r_lv      <= 1'b0;
      r_data    <= {c_DW{1'b0}};
      r_done    <= 1'b0;
      r_ok      <= 1'b0;
      r_err     <= 4'b0000;
      r_fcnt    <= 16'd0;
      r_dec_rst <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_beats   <= w_beats_nxt;
      r_lines   <= w_lines_nxt;
      r_max     <= w_max_nxt;
      r_bad     <= w_bad_nxt;
      r_fv      <= w_gate;
      r_lv      <= w_gate & line_valid_i;
      r_data    <= w_gate ? data_i : {c_DW{1'b0}};
      r_done    <= w_done;
      r_ok      <= w_done & w_ok;
      r_err     <= (clr_err_i ? 4'b0000 : r_err) | w_err_set;
      r_fcnt    <= (w_done && w_ok) ? r_fcnt + 16'd1 : r_fcnt;
      r_dec_rst <= w_state_nxt == RECOVER;
      r_busy    <= w_state_nxt != IDLE;
    end
  end

`ifdef MIPI_RX_FRAME_CTRL_STATS_EN
  logic [CNT_W-1:0] r_last_lines, r_last_max;

  // A restarted frame reports what it had accumulated before the new frame_start.
  always_ff @(posedge PARALLEL_CLOCK_I or posedge RESET_I) begin
    if (RESET_I) begin
      r_last_lines <= c_ZERO;
      r_last_max   <= c_ZERO;
    end else if (w_done) begin
      r_last_lines <= frame_start_i ? r_lines : w_lines_eff;
      r_last_max   <= frame_start_i ? r_max : w_max_eff;
    end else begin
      r_last_lines <= r_last_lines;
      r_last_max   <= r_last_max;
    end
  end

  assign last_lines_o     = r_last_lines;
  assign last_max_beats_o = r_last_max;
`endif

  assign frame_valid_o = r_fv;
  assign line_valid_o  = r_lv;
  assign data_o        = r_data;
  assign frame_done_o  = r_done;
  assign frame_ok_o    = r_ok;
  assign err_o         = r_err;
  assign frame_cnt_o   = r_fcnt;
  assign decoder_rst_o = r_dec_rst;
  assign busy_o        = r_busy;

endmodule

// File: tb/tb_mipi_rx_frame_ctrl.sv
// Directed bench for mipi_rx_frame_ctrl with a frame-done scoreboard (H=8, V=4, timeout 32, reset pulse 16).
module tb_mipi_rx_frame_ctrl;

  localparam int DW = 10;
  localparam int NP = 1;
  localparam int HR = 8;
  localparam int VR = 4;
  localparam int TO = 32;
  localparam int RC = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0, clr_err = 1'b0;
  logic fs = 1'b0, fe = 1'b0, ls = 1'b0, le = 1'b0, lv = 1'b0;
  logic [DW*NP-1:0] din = '0;

  logic fv_o, lv_o, done_o, ok_o, dec_rst_o, busy_o;
  logic [DW*NP-1:0] dout;
  logic [3:0]  err_o;
  logic [15:0] fcnt_o;
`ifdef MIPI_RX_FRAME_CTRL_STATS_EN
  logic [15:0] last_lines_o, last_max_o;
`endif

  typedef struct packed {
    logic        ok;
    logic [15:0] cnt;
    logic [3:0]  err;
  } done_t;

  done_t exp_q[$];
  done_t mon_e;
  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int rst_len;
  logic [15:0] exp_cnt = 16'd0;
  logic [3:0]  exp_err = 4'd0;
  logic [DW*NP-1:0] keep_d;

  always #5 clk = ~clk;

  mipi_rx_frame_ctrl #(
    .g_DATAWIDTH(DW), .g_NUM_OF_PIXELS(NP), .g_H_RES(HR), .g_V_RES(VR),
    .g_TIMEOUT(TO), .g_RST_CYCLES(RC)
  ) dut (
    .PARALLEL_CLOCK_I(clk), .RESET_I(rst), .enable_i(enable), .clr_err_i(clr_err),
    .frame_start_i(fs), .frame_end_i(fe), .line_start_i(ls), .line_end_i(le),
    .line_valid_i(lv), .data_i(din),
    .frame_valid_o(fv_o), .line_valid_o(lv_o), .data_o(dout),
    .frame_done_o(done_o), .frame_ok_o(ok_o), .err_o(err_o), .frame_cnt_o(fcnt_o),
`ifdef MIPI_RX_FRAME_CTRL_STATS_EN
    .last_lines_o(last_lines_o), .last_max_beats_o(last_max_o),
`endif
    .decoder_rst_o(dec_rst_o), .busy_o(busy_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every frame_done_o pulse consumes one expected verdict.
  always @(negedge clk) begin
    if (done_o === 1'b1) begin
      check("done_expected", (exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("frame_ok", ok_o, mon_e.ok);
        check("frame_cnt", fcnt_o, mon_e.cnt);
        check("err_at_done", err_o, mon_e.err);
      end
    end
  end

  task automatic step(input logic f_s, input logic f_e, input logic l_s, input logic l_e,
                      input logic l_v, input logic [DW*NP-1:0] d);
    fs = f_s; fe = f_e; ls = l_s; le = l_e; lv = l_v; din = d;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic expect_done(input logic ok, input logic [3:0] new_bits);
    done_t e;
    exp_err = exp_err | new_bits;
    if (ok) exp_cnt = exp_cnt + 16'd1;
    e.ok  = ok;
    e.cnt = exp_cnt;
    e.err = exp_err;
    exp_q.push_back(e);
  endtask

  task automatic send_line(input int beats, input bit with_fe);
    logic [DW*NP-1:0] d;
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    for (int b = 0; b < beats; b++) begin
      d = DW'($urandom_range(1, 1023));
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, d);
      check("lv_lag", lv_o, 1);
      check("data_lag", dout, d);
      check("fv_in_frame", fv_o, 1);
    end
    step(1'b0, with_fe, 1'b0, 1'b1, 1'b0, '0);
  endtask

  task automatic send_lines(input int n, input int short_idx, input bit coinc);
    for (int l = 0; l < n; l++)
      send_line((l == short_idx) ? HR - 1 : HR, coinc && (l == n - 1));
  endtask

  task automatic start_frame();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("fv_rise", fv_o, 1);
  endtask

  task automatic end_frame();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("fv_at_fe", fv_o, 1);
    idle();
    check("fv_after_fe", fv_o, 0);
  endtask

  task automatic clear_err();
    clr_err = 1'b1;
    idle();
    clr_err = 1'b0;
    exp_err = 4'd0;
    check("err_clr", err_o, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_fv", fv_o, 0);
    check("rst_lv", lv_o, 0);
    check("rst_data", dout, 0);
    check("rst_done", done_o, 0);
    check("rst_ok", ok_o, 0);
    check("rst_err", err_o, 0);
    check("rst_cnt", fcnt_o, 0);
    check("rst_dec_rst", dec_rst_o, 0);
    check("rst_busy", busy_o, 0);
    rst = 1'b0;
    idle();
    check("idle_busy", busy_o, 0);

    enable = 1'b1;
    idle();
    check("busy_wait_fs", busy_o, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'h155);
    check("wait_fs_lv_gated", lv_o, 0);
    check("wait_fs_data_gated", dout, 0);

    // Nominal frame.
    start_frame();
    send_lines(VR, -1, 1'b0);
    expect_done(1'b1, 4'b0000);
    end_frame();
    check("nominal_err", err_o, 0);

    // Short second line.
    start_frame();
    expect_done(1'b0, 4'b0001);
    send_lines(VR, 1, 1'b0);
    end_frame();
    clear_err();

    // Three lines, last line_end coincident with frame_end.
    start_frame();
    expect_done(1'b0, 4'b0010);
    send_lines(VR - 1, -1, 1'b1);
    idle();
    check("coinc_err", err_o, 4'b0010);
    clear_err();

    // Restart mid-frame, then a clean frame.
    start_frame();
    send_lines(2, -1, 1'b0);
    expect_done(1'b0, 4'b0100);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("fv_restart", fv_o, 1);
    expect_done(1'b1, 4'b0000);
    send_lines(VR, -1, 1'b0);
    end_frame();
    check("trunc_sticky", err_o, 4'b0100);
    clear_err();

    // Stall: timeout on the 32nd idle cycle, then a 16-cycle decoder reset.
    start_frame();
    send_lines(1, -1, 1'b0);
    for (int i = 0; i < TO - 1; i++) idle();
    check("to_not_early", err_o[3], 0);
    check("fv_before_to", fv_o, 1);
    idle();
    check("to_err", err_o, 4'b1000);
    check("to_fv_drop", fv_o, 0);
    check("to_dec_rst", dec_rst_o, 1);
    rst_len = 1;
    for (int k = 0; k < 40; k++) begin
      idle();
      if (dec_rst_o !== 1'b1) break;
      rst_len++;
    end
    check("dec_rst_len", rst_len, RC);
    check("recover_busy", busy_o, 1);
    clear_err();
    start_frame();
    expect_done(1'b1, 4'b0000);
    send_lines(VR, -1, 1'b0);
    end_frame();

    // enable dropped mid-frame: frame completes, then IDLE.
    start_frame();
    send_lines(2, -1, 1'b0);
    enable = 1'b0;
    expect_done(1'b1, 4'b0000);
    send_lines(2, -1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("dis_fv_at_fe", fv_o, 1);
    check("dis_busy", busy_o, 0);
    idle();
    check("dis_fv_after", fv_o, 0);

    // Asynchronous reset mid-line.
    enable = 1'b1;
    idle();
    start_frame();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    keep_d = 10'h2a5;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, keep_d);
    check("pre_rst_lv", lv_o, 1);
    check("pre_rst_cnt", fcnt_o, 16'd4);
    #2 rst = 1'b1;
    #1;
    check("arst_fv", fv_o, 0);
    check("arst_lv", lv_o, 0);
    check("arst_data", dout, 0);
    check("arst_busy", busy_o, 0);
    check("arst_cnt", fcnt_o, 0);
    check("arst_err", err_o, 0);
    @(negedge clk);
    lv = 1'b0;
    rst = 1'b0;
    idle();

    check("done_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
